// File: rtl/mux1to2_demux_collector.sv
// mux1to2_demux_collector
// Steers a stream of DW-bit words into one of two packing banks (A/B) by isel.
// Each bank packs DEPTH words, LSB-first, into a wide register and presents it
// with a valid/ack handshake. Select convention: isel=1 -> A, isel=0 -> B.
//
// Ports
//   iclk              clock, rising edge
//   irst              synchronous active-high reset
//   iD, isel, ivalid  input word, bank select, word valid
//   oready            word accepted when ivalid & oready (combinational on isel)
//   iflush            synchronous clear of both banks
//   oA, oA_valid      bank A packed data and full indication; iA_ack consumes it
//   oB, oB_valid      bank B packed data and full indication; iB_ack consumes it
//   oA_cnt, oB_cnt    words currently held in each bank
module mux1to2_demux_collector #(
  parameter int unsigned DW    = 4,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic                iclk,
  input  logic                irst,
  input  logic [DW-1:0]       iD,
  input  logic                isel,
  input  logic                ivalid,
  output logic                oready,
  input  logic                iflush,
  output logic [DW*DEPTH-1:0] oA,
  output logic                oA_valid,
  input  logic                iA_ack,
  output logic [DW*DEPTH-1:0] oB,
  output logic                oB_valid,
  input  logic                iB_ack,
  output logic [CW-1:0]       oA_cnt,
  output logic [CW-1:0]       oB_cnt
);

  typedef enum logic {StFill, StFull} bank_st_e;

  localparam logic [CW-1:0] LastIdx = CW'(DEPTH - 1);

  // Index 0 is bank A, index 1 is bank B.
  bank_st_e            st_q   [2];
  bank_st_e            st_d   [2];
  logic [DW*DEPTH-1:0] data_q [2];
  logic [DW*DEPTH-1:0] data_d [2];
  logic [CW-1:0]       cnt_q  [2];
  logic [CW-1:0]       cnt_d  [2];

  logic       accept;
  logic [1:0] ack_in;
  logic [1:0] wr_en;

  // Ready only reflects the selected bank so a producer can look ahead of ivalid.
  assign oready = isel ? (st_q[0] == StFill) : (st_q[1] == StFill);
  assign accept = ivalid & oready;
  assign ack_in = {iB_ack, iA_ack};
  assign wr_en  = {accept & ~isel, accept & isel};

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      st_d[b]   = st_q[b];
      data_d[b] = data_q[b];
      cnt_d[b]  = cnt_q[b];
      if (iflush) begin
        // Flush wins over ack and discards any same-cycle accept.
        st_d[b]   = StFill;
        data_d[b] = '0;
        cnt_d[b]  = '0;
      end else if (ack_in[b] && st_q[b] == StFull) begin
        st_d[b]   = StFill;
        data_d[b] = '0;
        cnt_d[b]  = '0;
      end else if (wr_en[b]) begin
        // wr_en implies StFill, so cnt_q is always a valid slot index here.
        data_d[b][cnt_q[b]*DW +: DW] = iD;
        cnt_d[b] = cnt_q[b] + 1'b1;
        if (cnt_q[b] == LastIdx) begin
          st_d[b] = StFull;
        end
      end
    end
  end

  always_ff @(posedge iclk) begin
    for (int b = 0; b < 2; b++) begin
      if (irst) begin
        st_q[b]   <= StFill;
        data_q[b] <= '0;
        cnt_q[b]  <= '0;
      end else begin
        st_q[b]   <= st_d[b];
        data_q[b] <= data_d[b];
        cnt_q[b]  <= cnt_d[b];
      end
    end
  end

  assign oA       = data_q[0];
  assign oB       = data_q[1];
  assign oA_cnt   = cnt_q[0];
  assign oB_cnt   = cnt_q[1];
  assign oA_valid = (st_q[0] == StFull);
  assign oB_valid = (st_q[1] == StFull);

endmodule

// File: tb/tb_mux1to2_demux_collector.sv
module tb_mux1to2_demux_collector;

  localparam int unsigned DW    = 4;
  localparam int unsigned DEPTH = 4;

  logic        iclk = 1'b0;
  logic        irst;
  logic [3:0]  iD;
  logic        isel;
  logic        ivalid;
  logic        oready;
  logic        iflush;
  logic [15:0] oA;
  logic        oA_valid;
  logic        iA_ack;
  logic [15:0] oB;
  logic        oB_valid;
  logic        iB_ack;
  logic [2:0]  oA_cnt;
  logic [2:0]  oB_cnt;

  int errors = 0;
  int checks = 0;

  logic [15:0] q_a [$];
  logic [15:0] q_b [$];

  always #5 iclk = ~iclk;

  mux1to2_demux_collector #(
    .DW   (DW),
    .DEPTH(DEPTH)
  ) dut (
    .iclk    (iclk),
    .irst    (irst),
    .iD      (iD),
    .isel    (isel),
    .ivalid  (ivalid),
    .oready  (oready),
    .iflush  (iflush),
    .oA      (oA),
    .oA_valid(oA_valid),
    .iA_ack  (iA_ack),
    .oB      (oB),
    .oB_valid(oB_valid),
    .iB_ack  (iB_ack),
    .oA_cnt  (oA_cnt),
    .oB_cnt  (oB_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic send(input logic sel, input logic [3:0] d);
    isel   = sel;
    iD     = d;
    ivalid = 1'b1;
    tick();
    ivalid = 1'b0;
  endtask

  initial begin
    irst = 1'b1; iD = 4'h5; isel = 1'b1; ivalid = 1'b1;
    iflush = 1'b0; iA_ack = 1'b0; iB_ack = 1'b0;

    // Monitor: a rising oX_valid is a presented bank, compared against the scoreboard.
    fork
      begin
        logic a_prev = 1'b0;
        logic b_prev = 1'b0;
        forever begin
          @(negedge iclk);
          if (oA_valid && !a_prev) begin
            if (q_a.size() == 0) chk("unexpected_A", 32'(oA), 32'hDEAD_0000);
            else begin
              chk("bank_A_data", 32'(oA), 32'(q_a.pop_front()));
              chk("bank_A_cnt", 32'(oA_cnt), DEPTH);
            end
          end
          if (oB_valid && !b_prev) begin
            if (q_b.size() == 0) chk("unexpected_B", 32'(oB), 32'hDEAD_0000);
            else begin
              chk("bank_B_data", 32'(oB), 32'(q_b.pop_front()));
              chk("bank_B_cnt", 32'(oB_cnt), DEPTH);
            end
          end
          a_prev = oA_valid;
          b_prev = oB_valid;
        end
      end
    join_none

    // 1: reset held two cycles with ivalid asserted
    tick();
    tick();
    chk("rst_oA", 32'(oA), 0);
    chk("rst_oB", 32'(oB), 0);
    chk("rst_cntA", 32'(oA_cnt), 0);
    chk("rst_cntB", 32'(oB_cnt), 0);
    chk("rst_validA", 32'(oA_valid), 0);
    chk("rst_validB", 32'(oB_valid), 0);
    irst = 1'b0; ivalid = 1'b0;
    #1 chk("rst_ready_A", 32'(oready), 1);
    isel = 1'b0;
    #1 chk("rst_ready_B", 32'(oready), 1);

    // 2: fill A with 1,2,3,4
    q_a.push_back(16'h4321);
    for (int i = 1; i <= 4; i++) send(1'b1, 4'(i));
    chk("fill_validA", 32'(oA_valid), 1);
    chk("fill_validB", 32'(oB_valid), 0);
    chk("fill_cntB", 32'(oB_cnt), 0);

    // 3: back-pressure on full A, then ack
    isel = 1'b1; iD = 4'hF; ivalid = 1'b1;
    #1 chk("bp_ready", 32'(oready), 0);
    tick();
    ivalid = 1'b0;
    chk("bp_oA_hold", 32'(oA), 32'h4321);
    chk("bp_cnt_hold", 32'(oA_cnt), 4);
    iA_ack = 1'b1;
    tick();
    iA_ack = 1'b0;
    chk("ack_oA", 32'(oA), 0);
    chk("ack_validA", 32'(oA_valid), 0);
    chk("ack_cntA", 32'(oA_cnt), 0);
    chk("ack_ready", 32'(oready), 1);

    // 4: interleave 1..8, odd words to A, even to B
    q_a.push_back(16'h7531);
    q_b.push_back(16'h8642);
    for (int i = 1; i <= 8; i++) send(i[0], 4'(i));
    chk("ilv_both_valid", 32'({oA_valid, oB_valid}), 32'b11);
    chk("ilv_oA", 32'(oA), 32'h7531);

    // 5: free B, then ack A concurrent with an accept to B
    iB_ack = 1'b1;
    tick();
    iB_ack = 1'b0;
    chk("ackB_cnt", 32'(oB_cnt), 0);
    chk("ackB_A_kept", 32'(oA_valid), 1);
    iA_ack = 1'b1;
    send(1'b0, 4'h9);
    iA_ack = 1'b0;
    chk("conc_validA", 32'(oA_valid), 0);
    chk("conc_oA", 32'(oA), 0);
    chk("conc_cntB", 32'(oB_cnt), 1);
    chk("conc_oB_lo", 32'(oB[3:0]), 9);
    // Ack of a non-full bank is ignored
    iB_ack = 1'b1;
    tick();
    iB_ack = 1'b0;
    chk("ign_ack_cntB", 32'(oB_cnt), 1);
    chk("ign_ack_oB", 32'(oB), 32'h0009);

    // 6: flush mid-fill discards the same-cycle word
    send(1'b0, 4'h3);
    chk("pre_flush_cntB", 32'(oB_cnt), 2);
    iflush = 1'b1;
    send(1'b0, 4'h7);
    iflush = 1'b0;
    chk("flush_oB", 32'(oB), 0);
    chk("flush_cntB", 32'(oB_cnt), 0);
    chk("flush_cntA", 32'(oA_cnt), 0);

    // Refill B after flush, then flush clears a full bank too
    q_b.push_back(16'hDCBA);
    send(1'b0, 4'hA);
    send(1'b0, 4'hB);
    send(1'b0, 4'hC);
    send(1'b0, 4'hD);
    chk("refill_validB", 32'(oB_valid), 1);
    iflush = 1'b1; iB_ack = 1'b1;
    tick();
    iflush = 1'b0; iB_ack = 1'b0;
    chk("flush_full_validB", 32'(oB_valid), 0);
    chk("flush_full_oB", 32'(oB), 0);

    // Give the monitor a bounded window to drain the scoreboard
    for (int i = 0; i < 4; i++) tick();
    chk("sb_A_drained", 32'(q_a.size()), 0);
    chk("sb_B_drained", 32'(q_b.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
